// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: requester-side bus of the shared logic unit arbiter
// master: requester side drives req/op/a/b, receives gnt/done/result/busy
// slave : arbiter side; is_zero exists only when LU_ZERO_FLAG_EN is defined
interface logic_unit_arbiter_if #(parameter int WIDTH = 32);
  logic req0, req1, gnt0, gnt1, done0, done1, busy;
  logic [1:0] op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1, result;
`ifdef LU_ZERO_FLAG_EN
  logic is_zero;
`endif
  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input gnt0, gnt1, done0, done1, result, busy
`ifdef LU_ZERO_FLAG_EN
    , input is_zero
`endif
  );
  modport slave (
    input req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
`ifdef LU_ZERO_FLAG_EN
    , output is_zero
`endif
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one NOT/AND/OR/XOR unit between two ports
// clock: rising-edge clock; reset: synchronous active-low
// bus (slave): req/op/a/b per port in; gnt/done pulses, registered result, busy out
// LU_ZERO_FLAG_EN: adds registered is_zero flag written with result
module logic_unit_arbiter #(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset,
  logic_unit_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last_owner, owner, win1, any_req;
  logic [1:0] op_l;
  logic [WIDTH-1:0] a_l, b_l, f;
  always_comb begin
    any_req = bus.req0 | bus.req1;
    // port 1 wins alone, or on a tie when port 0 owned the unit last
    win1 = bus.req1 & (~bus.req0 | ~last_owner);
    f = op_l == 2'b00 ? ~a_l :
        op_l == 2'b01 ? a_l & b_l :
        op_l == 2'b10 ? a_l | b_l : a_l ^ b_l;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.result <= '0;
`ifdef LU_ZERO_FLAG_EN
      bus.is_zero <= 1'b0;
`endif
      last_owner <= 1'b1;
      owner <= 1'b0;
      op_l <= 2'b00;
      a_l <= '0;
      b_l <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= win1;
          last_owner <= win1;
          op_l <= win1 ? bus.op1 : bus.op0;
          a_l <= win1 ? bus.a1 : bus.a0;
          b_l <= win1 ? bus.b1 : bus.b0;
          bus.gnt0 <= ~win1;
          bus.gnt1 <= win1;
          bus.busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          bus.gnt0 <= 1'b0;
          bus.gnt1 <= 1'b0;
          bus.result <= f;
`ifdef LU_ZERO_FLAG_EN
          bus.is_zero <= f == '0;
`endif
          bus.done0 <= ~owner;
          bus.done1 <= owner;
          state <= RESP;
        end
        RESP: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
